// File: rtl/csa_result_collector_if.sv
// Upstream/downstream handshake bundle for csa_result_collector.
// slave = collector side, master = producer/consumer side.
interface csa_result_collector_if #(
  parameter int WIDTH = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic [WIDTH-1:0] i_sum;
  logic             i_cout;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH:0]   o_result;
  logic             o_mismatch;

  modport slave (
    input  i_valid,
    input  i_add_term1,
    input  i_add_term2,
    input  i_sum,
    input  i_cout,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_result,
    output o_mismatch
  );

  modport master (
    output i_valid,
    output i_add_term1,
    output i_add_term2,
    output i_sum,
    output i_cout,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_result,
    input  o_mismatch
  );
endinterface

// File: rtl/csa_result_collector.sv
// Captures adder results, checks them against a golden sum and
// buffers {mismatch, result} in a FWFT FIFO with saturating stats.
module csa_result_collector #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  csa_result_collector_if.slave bus,
  output logic [CNT_W-1:0]     o_txn_count,
  output logic [CNT_W-1:0]     o_err_count,
  output logic                 o_sticky_err,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = WIDTH + 1;
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  typedef logic [RW:0] entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     occ;
  logic [PW:0]     occ_nxt;
  logic            push;
  logic            pop;
  logic            mismatch;
  logic [RW-1:0]   golden;
  logic [RW-1:0]   adder_res;
  entry_t          head;

  // ready depends only on registered full and reset, never on i_ready
  assign bus.o_ready = !o_full && !i_rst;
  assign push        = bus.i_valid && bus.o_ready;
  assign bus.o_valid = !o_empty;
  assign pop         = bus.o_valid && bus.i_ready;

  assign golden    = RW'(bus.i_add_term1) + RW'(bus.i_add_term2);
  assign adder_res = {bus.i_cout, bus.i_sum};
  assign mismatch  = golden != adder_res;

  assign head           = o_empty ? '0 : mem[rd_ptr];
  assign bus.o_mismatch = head[RW];
  assign bus.o_result   = head[RW-1:0];

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {mismatch, adder_res};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      o_full       <= 1'b0;
      o_empty      <= 1'b1;
      o_txn_count  <= '0;
      o_err_count  <= '0;
      o_sticky_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ     <= occ_nxt;
      o_full  <= occ_nxt == OCC_FULL;
      o_empty <= occ_nxt == '0;
      if (push && o_txn_count != '1) begin
        o_txn_count <= o_txn_count + 1'b1;
      end
      if (push && mismatch && o_err_count != '1) begin
        o_err_count <= o_err_count + 1'b1;
      end
      if (push && mismatch) begin
        o_sticky_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_csa_result_collector.sv
// Scoreboard bench for csa_result_collector: queue-based reference
// model plus a second instance with CNT_W=2 for counter saturation.
module tb_csa_result_collector;
  localparam int W  = 5;
  localparam int D  = 4;
  localparam int C  = 16;
  localparam int C2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_result_collector_if #(.WIDTH(W)) bus ();
  csa_result_collector_if #(.WIDTH(W)) bus2 ();

  logic [C-1:0]  txn_count, err_count;
  logic          sticky_err, full, empty;
  logic [C2-1:0] txn_count2, err_count2;
  logic          sticky_err2, full2, empty2;

  assign bus2.i_valid     = bus.i_valid;
  assign bus2.i_add_term1 = bus.i_add_term1;
  assign bus2.i_add_term2 = bus.i_add_term2;
  assign bus2.i_sum       = bus.i_sum;
  assign bus2.i_cout      = bus.i_cout;
  assign bus2.i_ready     = bus.i_ready;

  csa_result_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_txn_count  (txn_count),
    .o_err_count  (err_count),
    .o_sticky_err (sticky_err),
    .o_full       (full),
    .o_empty      (empty)
  );

  csa_result_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(C2)) dut_sat (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus2),
    .o_txn_count  (txn_count2),
    .o_err_count  (err_count2),
    .o_sticky_err (sticky_err2),
    .o_full       (full2),
    .o_empty      (empty2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, counts as plain integers
  logic [W+1:0] q[$];
  int  m_txn, m_err;
  bit  m_sticky;
  bit  armed = 0;
  bit  rand_rdy = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    bit           rdy;
    logic [W+1:0] hd;
    int           gold, got;
    bit           mm;
    if (armed) begin
      rdy = !rst && (q.size() < D);
      hd  = (q.size() != 0) ? q[0] : '0;
      chk("o_ready", 32'(bus.o_ready), 32'(rdy));
      chk("o_valid", 32'(bus.o_valid), 32'(q.size() != 0));
      chk("o_empty", 32'(empty), 32'(q.size() == 0));
      chk("o_full", 32'(full), 32'(q.size() == D));
      chk("head", 32'({bus.o_mismatch, bus.o_result}), 32'(hd));
      chk("txn_count", 32'(txn_count), 32'(sat(m_txn, C)));
      chk("err_count", 32'(err_count), 32'(sat(m_err, C)));
      chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
      chk("sat_txn", 32'(txn_count2), 32'(sat(m_txn, C2)));
      chk("sat_err", 32'(err_count2), 32'(sat(m_err, C2)));
      chk("sat_ready", 32'(bus2.o_ready), 32'(rdy));
      if (rst) begin
        q.delete();
        m_txn = 0;
        m_err = 0;
        m_sticky = 0;
      end else begin
        if (q.size() != 0 && bus.i_ready) begin
          void'(q.pop_front());
        end
        if (bus.i_valid && rdy) begin
          gold = int'(bus.i_add_term1) + int'(bus.i_add_term2);
          got  = int'({bus.i_cout, bus.i_sum});
          mm   = gold != got;
          q.push_back({mm, bus.i_cout, bus.i_sum});
          m_txn++;
          if (mm) begin
            m_err++;
            m_sticky = 1;
          end
        end
      end
    end else if (rst) begin
      q.delete();
      m_txn = 0;
      m_err = 0;
      m_sticky = 0;
      armed = 1;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.i_ready = ($urandom % 4) != 0;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] s, input logic c);
    int k;
    bus.i_valid     = 1'b1;
    bus.i_add_term1 = a;
    bus.i_add_term2 = b;
    bus.i_sum       = s;
    bus.i_cout      = c;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_ready) break;
    end
    if (k == 200) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic push_ok(input int a, input int b);
    logic [W:0] r;
    r = (W+1)'(a + b);
    push(W'(a), W'(b), r[W-1:0], r[W]);
  endtask

  task automatic drain();
    int k;
    bus.i_ready = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (k == 100) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [W:0] r;
    int a, b;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_add_term1 = '0;
    bus.i_add_term2 = '0;
    bus.i_sum = '0;
    bus.i_cout = 1'b0;
    @(posedge clk);
    #1 do_reset();

    // single correct push, visible next cycle
    bus.i_ready = 1'b1;
    push(5'd13, 5'd9, 5'd22, 1'b0);
    @(negedge clk);
    chk("t1_result", 32'(bus.o_result), 32'(6'b010110));
    chk("t1_txn", 32'(txn_count), 32'd1);
    @(posedge clk);
    #1;

    // carry-out case, then injected error
    push(5'd31, 5'd31, 5'b11110, 1'b1);
    push(5'd31, 5'd31, 5'b11111, 1'b1);
    @(negedge clk);
    chk("t2_sticky", 32'(sticky_err), 32'd1);
    chk("t2_err", 32'(err_count), 32'd1);
    @(posedge clk);
    #1 drain();

    // fill to full with i_ready low; fifth push must wait
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_ok(i, i);
    fork
      push_ok(5, 5);
      begin
        repeat (3) @(negedge clk);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_ready", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
    join
    drain();

    // steady push/pop at occupancy 2
    bus.i_ready = 1'b0;
    push_ok(3, 4);
    push_ok(7, 8);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_ok(i * 3, i + 1);
    drain();

    // randomized traffic with error injection and random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      r = (W+1)'(a + b);
      if (($urandom % 4) == 0) r = r ^ (W+1)'(1 << $urandom_range(0, W));
      push(W'(a), W'(b), r[W-1:0], r[W]);
    end
    rand_rdy = 0;
    @(posedge clk);
    #2 drain();

    // reset with buffered entries and two errors
    do_reset();
    bus.i_ready = 1'b0;
    push(5'd1, 5'd2, 5'd4, 1'b0);
    push_ok(6, 7);
    push(5'd10, 5'd10, 5'd20, 1'b1);
    @(negedge clk);
    chk("t7_err", 32'(err_count), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t7_ready_rst", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t7_valid", 32'(bus.o_valid), 32'd0);
    chk("t7_txn", 32'(txn_count), 32'd0);
    chk("t7_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;

    // five mismatching pushes saturate the narrow counters
    bus.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(W'(i), 5'd1, 5'd0, 1'b1);
    @(negedge clk);
    chk("t8_txn2", 32'(txn_count2), 32'd3);
    chk("t8_err2", 32'(err_count2), 32'd3);
    chk("t8_txn", 32'(txn_count), 32'd5);
    @(posedge clk);
    #1 drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csa_result_collector.md
Name: csa_result_collector

Overview:
- Downstream capture stage for the generated carry-select adder batch.
- Takes each operand pair together with the adder's combinational sum/cout, registers the result and checks it against a behavioural golden sum.
- Buffers {mismatch, result} in a small FIFO for readout.
- Keeps saturating transaction and error counters so batch runs can classify a failing adder netlist.

Parameters:
- WIDTH, 5, operand/sum width; result is WIDTH+1 bits including cout.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, 16, width of transaction and error counters.

Ports:
- i_clk  input  1  single clock, all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  upstream presents operands plus adder outputs
- o_ready  output  1  collector can accept this cycle
- i_add_term1  input  WIDTH  operand A as driven into adder
- i_add_term2  input  WIDTH  operand B as driven into adder
- i_sum  input  WIDTH  adder sum output
- i_cout  input  1  adder carry output
- o_valid  output  1  FIFO head entry available
- i_ready  input  1  downstream consumes head entry
- o_result  output  WIDTH+1  head entry result {cout, sum}
- o_mismatch  output  1  head entry disagreed with golden sum
- o_txn_count  output  CNT_W  accepted transactions, saturating
- o_err_count  output  CNT_W  mismatching transactions, saturating
- o_sticky_err  output  1  set on first mismatch, cleared only by reset
- o_full  output  1  FIFO holds DEPTH entries
- o_empty  output  1  FIFO holds 0 entries

Behaviour:
- Clock and reset: one clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset (i_rst sampled high):
  - FIFO pointers and occupancy cleared; counters = 0; o_sticky_err = 0.
  - o_valid = 0, o_empty = 1, o_full = 0.
  - o_result/o_mismatch = 0 while empty.
  - o_ready forced 0 in any cycle where i_rst is high.
  - Reset mid-operation discards all buffered entries; counts are not preserved.
- Accept:
  - push = i_valid & o_ready, where o_ready = !o_full & !i_rst.
  - No combinational path from i_ready to o_ready.
  - When full, a same-cycle pop does not enable a push; the upstream holds and retries the next cycle.
- Golden check, on push:
  - expected = zero-extended i_add_term1 + i_add_term2, WIDTH+1 bits, no truncation.
  - mismatch = (expected != {i_cout, i_sum}).
  - Entry written = {mismatch, i_cout, i_sum}.
  - Stored result is the adder's value, not the golden value.
- Readout:
  - First-word-fall-through: o_valid = !o_empty.
  - o_result/o_mismatch reflect the head entry combinationally from registered storage.
  - pop = o_valid & i_ready.
  - o_result, o_mismatch and o_valid must stay stable while o_valid=1 and i_ready=0.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1. There is no bypass.
- Simultaneous push and pop (non-empty, non-full): occupancy unchanged; both pointers advance.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. Occupancy counter is 0..DEPTH and drives o_full/o_empty (registered).
- Counters:
  - o_txn_count increments on each push; o_err_count increments on each push with mismatch=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - o_sticky_err set in the cycle after the first mismatching push.
- i_valid with o_ready=0: no state change. Data may change freely; there is no stability requirement on the upstream beyond the handshake.
- Pop on empty is impossible because o_valid=0. i_ready is ignored when empty.

Test Plan:
- Reset then single push 13+9 with i_sum=22, i_cout=0, i_ready=1:
  - Next cycle o_valid=1, o_result=6'b010110, o_mismatch=0.
  - o_txn_count=1, o_err_count=0.
- Push 31+31 with correct {1,11110}, then the same operands with injected i_sum=11111:
  - Entries read as 62/0 and 63/1.
  - o_err_count=1; o_sticky_err=1 from the cycle after the second push.
- i_ready=0, five back-to-back pushes of 1+1..5+5:
  - o_full=1 and o_ready=0 after the 4th push; 5th held.
  - Raising i_ready drains 2, 4, 6, 8, then the 5th accepted and read as 10, in order.
- Continuous push and pop at 2 entries occupancy for 10 cycles:
  - Occupancy stays 2; pointers wrap cleanly.
  - Output order matches input order with no drop or duplicate.
- Assert i_rst with 3 entries buffered and o_err_count=2:
  - Next cycle o_valid=0, o_empty=1, counts=0, o_sticky_err=0.
  - o_ready=0 during reset, 1 after.
- CNT_W=2, 5 mismatching pushes with draining: both counters stick at 3.
